memory_unit_host: RTL and testbench

- Initiator for the 8x8 memory unit (FSM + address decoder + 8 wordcells).
- Accepts single-word read/write requests from an upstream valid/ready port and drives the unit's op/select/adr/in lines in the sequence its FSM requires.
- Waits for the unit's valid/rw acknowledge, captures read data, and returns one response per request, with a timeout error path.
- Sits between any bus master (bench, CPU stub) and the memory unit.

---
 rtl/memory_unit_pkg.sv | 35 +++
 rtl/memory_unit_host_timer.sv | 28 ++
 rtl/memory_unit_host.sv | 223 ++++++++++++++++++++++
 tb/tb_memory_unit_host.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_pkg.sv
// Shared definitions for the memory unit host: FSM states, memory line
// encodings, bus widths and the upstream request payload.
package memory_unit_pkg;

  localparam int unsigned ADR_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  // Memory line encodings
  localparam logic OP_WRITE     = 1'b1;
  localparam logic OP_READ      = 1'b0;
  localparam logic SEL_ACTIVE   = 1'b1;
  localparam logic SEL_HOLD     = 1'b0;
  localparam logic MEM_RW_READ  = 1'b1;
  localparam logic MEM_RW_WRITE = 1'b0;

  // Memory FSM state {A,B} when idle
  localparam logic [1:0] MEM_IDLE_AB = 2'b11;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR,
    RD,
    SETTLE,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/memory_unit_host_timer.sv
// Loadable saturating down-counter shared by the host FSM phases.
// Ports: clk, rst (sync, active-high), load/load_val (reload),
//        count (registered value), done_c (count has reached zero).
module memory_unit_host_timer
  import memory_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done_c
);

  // Load wins over decrement; holds at zero once reached
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/memory_unit_host.sv
// Initiator for the 8x8 memory unit. Takes single-word read/write requests
// on a valid/ready port, sequences the memory op/select/adr/in lines, waits
// for the valid/rw acknowledge (with timeout) and returns one response.
// Ports:
//   clk, rst                      clock, sync active-high reset
//   req_valid/req_ready           upstream request handshake
//   req_write/req_adr/req_data    request payload
//   resp_valid/resp_ready         response handshake
//   resp_data/resp_err            read data (0 for writes/errors), timeout flag
//   mem_op/mem_select/mem_adr/mem_in   memory command lines
//   mem_out/mem_valid/mem_rw/mem_a/mem_b  memory status and read data
module memory_unit_host
  import memory_unit_pkg::*;
#(
  parameter int unsigned INIT_CYCLES    = 3,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_op,
  output logic              mem_select,
  output logic [ADR_W-1:0]  mem_adr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_valid,
  input  logic              mem_rw,
  input  logic              mem_a,
  input  logic              mem_b
);

  // INIT spends one cycle arming the timer, so the load is two short
  localparam logic [CNT_W-1:0] INIT_LOAD   = (INIT_CYCLES > 2) ? CNT_W'(INIT_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] TMO_LOAD    = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  state_t            state, state_n;
  logic              init_armed, init_armed_n;
  logic              init_ext, init_ext_n;
  logic              req_ready_n, resp_valid_n, resp_err_n;
  logic [DATA_W-1:0] resp_data_n;
  logic              mem_op_n, mem_select_n;
  logic [ADR_W-1:0]  mem_adr_n;
  logic [DATA_W-1:0] mem_in_n;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic [CNT_W-1:0]  tmr_count;
  logic              tmr_done_c;

  req_t              req_in_c;
  logic [1:0]        mem_ab_c;
  logic              first_c;
  logic              ack_c;

  assign req_in_c = '{write: req_write, adr: req_adr, data: req_data};
  assign mem_ab_c = {mem_a, mem_b};
  // Timer still holds its load value only in the first wait cycle
  assign first_c  = (tmr_count == TMO_LOAD);
  // Acknowledge counts only with the rw direction matching the operation
  assign ack_c    = mem_valid && (mem_rw == ((state == RD) ? MEM_RW_READ : MEM_RW_WRITE));

  memory_unit_host_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done_c   (tmr_done_c)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      init_armed <= 1'b0;
      init_ext   <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      mem_op     <= OP_READ;
      mem_select <= SEL_HOLD;
      mem_adr    <= '0;
      mem_in     <= '0;
    end else begin
      state      <= state_n;
      init_armed <= init_armed_n;
      init_ext   <= init_ext_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_data  <= resp_data_n;
      resp_err   <= resp_err_n;
      mem_op     <= mem_op_n;
      mem_select <= mem_select_n;
      mem_adr    <= mem_adr_n;
      mem_in     <= mem_in_n;
    end
  end

  // Next state and next output values
  always_comb begin
    logic go_idle;
    logic go_settle;

    state_n      = state;
    init_armed_n = init_armed;
    init_ext_n   = init_ext;
    req_ready_n  = req_ready;
    resp_valid_n = resp_valid;
    resp_data_n  = resp_data;
    resp_err_n   = resp_err;
    mem_op_n     = mem_op;
    mem_select_n = mem_select;
    mem_adr_n    = mem_adr;
    mem_in_n     = mem_in;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    go_idle      = 1'b0;
    go_settle    = 1'b0;

    unique case (state)
      INIT: begin
        mem_op_n     = OP_READ;
        mem_select_n = SEL_HOLD;
        if (!init_armed) begin
          init_armed_n = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = INIT_LOAD;
        end else if ((init_ext || tmr_done_c) && (mem_ab_c == MEM_IDLE_AB)) begin
          go_idle = 1'b1;
        end else if (tmr_done_c) begin
          // Memory not idle yet: wait a bounded extra interval, then proceed
          if (init_ext) begin
            go_idle = 1'b1;
          end else begin
            init_ext_n = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = TMO_LOAD;
          end
        end
      end

      IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_n  = 1'b0;
          mem_select_n = SEL_ACTIVE;
          mem_adr_n    = req_in_c.adr;
          tmr_load     = 1'b1;
          tmr_val      = TMO_LOAD;
          if (req_in_c.write) begin
            state_n  = WR;
            mem_op_n = OP_WRITE;
            mem_in_n = req_in_c.data;
          end else begin
            state_n  = RD;
            mem_op_n = OP_READ;
          end
        end
      end

      WR, RD: begin
        if (!first_c && ack_c) begin
          go_settle   = 1'b1;
          resp_err_n  = 1'b0;
          resp_data_n = (state == RD) ? mem_out : '0;
        end else if (tmr_done_c) begin
          go_settle   = 1'b1;
          resp_err_n  = 1'b1;
          resp_data_n = '0;
        end
      end

      SETTLE: begin
        if (tmr_done_c) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          mem_adr_n    = '0;
          mem_in_n     = '0;
        end
      end

      RESP: begin
        if (resp_valid && resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
          resp_err_n   = 1'b0;
          resp_data_n  = '0;
          req_ready_n  = 1'b1;
        end
      end

      default: begin
        state_n = INIT;
      end
    endcase

    if (go_idle) begin
      state_n      = IDLE;
      req_ready_n  = 1'b1;
      init_armed_n = 1'b0;
      init_ext_n   = 1'b0;
    end

    if (go_settle) begin
      state_n      = SETTLE;
      mem_op_n     = OP_READ;
      mem_select_n = SEL_HOLD;
      tmr_load     = 1'b1;
      tmr_val      = SETTLE_LOAD;
    end
  end

endmodule

// File: tb/tb_memory_unit_host.sv
// Scoreboard bench for memory_unit_host with a behavioural memory responder.
module tb_memory_unit_host;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write;
  logic [2:0] req_adr;
  logic [7:0] req_data;
  logic       resp_valid, resp_ready, resp_err;
  logic [7:0] resp_data;
  logic       mem_op, mem_select;
  logic [2:0] mem_adr;
  logic [7:0] mem_in, mem_out;
  logic       mem_valid, mem_rw, mem_a, mem_b;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         ack_mode = 0;   // 0 normal, 1 never ack, 2 ack with wrong rw
  logic [7:0] mem_arr[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_unit_host dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_adr    (req_adr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_op     (mem_op),
    .mem_select (mem_select),
    .mem_adr    (mem_adr),
    .mem_in     (mem_in),
    .mem_out    (mem_out),
    .mem_valid  (mem_valid),
    .mem_rw     (mem_rw),
    .mem_a      (mem_a),
    .mem_b      (mem_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: acks from the first cycle select is seen active
  initial begin
    mem_valid = 1'b0;
    mem_rw    = 1'b0;
    mem_out   = 8'h00;
    for (int i = 0; i < 8; i++) mem_arr[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_select && ack_mode == 0) begin
        mem_valid = 1'b1;
        mem_rw    = !mem_op;
        if (mem_op) mem_arr[mem_adr] = mem_in;
        else        mem_out = mem_arr[mem_adr];
      end else if (mem_select && ack_mode == 2) begin
        mem_valid = 1'b1;
        mem_rw    = mem_op;
      end else begin
        mem_valid = 1'b0;
        mem_rw    = 1'b0;
      end
    end
  end

  // Monitor: pops and compares on each accepted response
  initial begin
    bit   seen;
    int   lat;
    exp_t e;
    seen = 1'b0;
    lat  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 1'b0;
      end else if (resp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          lat  = cyc - acc_cyc;
        end
        if (resp_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got data %0h err %0b with nothing expected", resp_data, resp_err);
          end else begin
            e = sb.pop_front();
            check("resp_data", 32'(resp_data), 32'(e.data));
            check("resp_err", 32'(resp_err), 32'(e.err));
            check("resp_latency", 32'(lat), 32'(e.lat));
          end
          seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_init(input string name);
    int n = 0;
    while (!req_ready && n < 40) begin
      check({name, "_select"}, 32'(mem_select), 0);
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 3);
  endtask

  task automatic issue(input bit wr, input logic [2:0] adr, input logic [7:0] data,
                       input logic [7:0] exp_data, input bit exp_err, input int exp_lat);
    int n = 0;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 60 cycles");
      return;
    end
    req_valid = 1'b1;
    req_write = wr;
    req_adr   = adr;
    req_data  = data;
    acc_cyc   = cyc;
    sb.push_back('{data: exp_data, err: exp_err, lat: exp_lat});
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_drop", 32'(req_ready), 0);
    check("mem_select_active", 32'(mem_select), 1);
    check("mem_op", 32'(mem_op), 32'(wr));
    check("mem_adr", 32'(mem_adr), 32'(adr));
    if (wr) check("mem_in", 32'(mem_in), 32'(data));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_adr    = 3'd0;
    req_data   = 8'h00;
    resp_ready = 1'b1;
    mem_a      = 1'b1;
    mem_b      = 1'b1;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_resp_err", 32'(resp_err), 0);
    check("rst_mem_op", 32'(mem_op), 0);
    check("rst_mem_select", 32'(mem_select), 0);
    check("rst_mem_adr", 32'(mem_adr), 0);
    check("rst_mem_in", 32'(mem_in), 0);
    rst = 1'b0;
    wait_init("init_cycles");

    // Write then read-back
    issue(1'b1, 3'd0, 8'h55, 8'h00, 1'b0, 5);
    drain();
    check("mem_arr0", 32'(mem_arr[0]), 32'h55);
    issue(1'b0, 3'd0, 8'h00, 8'h55, 1'b0, 5);
    drain();
    issue(1'b1, 3'd7, 8'hA3, 8'h00, 1'b0, 5);
    drain();
    issue(1'b0, 3'd7, 8'h00, 8'hA3, 1'b0, 5);
    drain();

    // Timeout with no acknowledge
    ack_mode = 1;
    issue(1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 11);
    drain();
    check("tmo_mem_select", 32'(mem_select), 0);
    check("tmo_mem_op", 32'(mem_op), 0);

    // Acknowledge with wrong direction is ignored
    ack_mode = 2;
    issue(1'b0, 3'd7, 8'h00, 8'h00, 1'b1, 11);
    drain();
    ack_mode = 0;

    // Backpressure on the response
    resp_ready = 1'b0;
    issue(1'b0, 3'd0, 8'h00, 8'h55, 1'b0, 5);
    for (int n = 0; n < 40 && !resp_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 1);
      check("bp_resp_data", 32'(resp_data), 32'h55);
      check("bp_req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    drain();
    check("bp_req_ready_after", 32'(req_ready), 1);
    check("bp_resp_valid_after", 32'(resp_valid), 0);

    // Reset in the middle of a write
    ack_mode = 1;
    issue(1'b1, 3'd2, 8'h77, 8'h00, 1'b0, 5);
    repeat (2) @(negedge clk);
    check("mid_select_before", 32'(mem_select), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_select", 32'(mem_select), 0);
    check("mid_mem_op", 32'(mem_op), 0);
    check("mid_resp_valid", 32'(resp_valid), 0);
    check("mid_req_ready", 32'(req_ready), 0);
    sb.delete();
    rst = 1'b0;
    ack_mode = 0;
    wait_init("reinit_cycles");
    issue(1'b1, 3'd2, 8'h77, 8'h00, 1'b0, 5);
    drain();
    issue(1'b0, 3'd2, 8'h00, 8'h77, 1'b0, 5);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
